// File: rtl/fme_csr_pkg.sv
// fme_csr_pkg: register offsets, DFH layout and reset values shared by the FME CSR block
package fme_csr_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned FME_DFH_OFF        = 'h0000;
    localparam int unsigned AFU_ID_L_OFF       = 'h0008;
    localparam int unsigned AFU_ID_H_OFF       = 'h0010;
    localparam int unsigned NEXT_AFU_OFF       = 'h0018;
    localparam int unsigned SCRATCHPAD0_OFF    = 'h0028;
    localparam int unsigned FAB_CAPABILITY_OFF = 'h0030;
    localparam int unsigned FAB_STATUS_OFF     = 'h0058;
    localparam int unsigned BITSTREAM_ID_OFF   = 'h0060;
    localparam int unsigned BITSTREAM_MD_OFF   = 'h0068;
    localparam int unsigned FME_ERROR_MASK_OFF = 'h4000;
    localparam int unsigned FME_ERROR_OFF      = 'h4008;

    typedef struct packed {
        logic [3:0]  feature_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next;
        logic [3:0]  ver;
        logic [11:0] id;
    } dfh_t;

    localparam dfh_t FME_DFH = '{feature_type: 4'h4, rsvd: 19'h0, eol: 1'b0,
                                 next: 24'h004000, ver: 4'h1, id: 12'h000};

    localparam logic [63:0] SCRATCHPAD_RST = 64'h0;
    localparam logic [63:0] ERROR_MASK_RST = 64'h0;
    localparam logic [63:0] ERROR_RST      = 64'h0;

    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/fme_csr_axi_regs_if.sv
// fme_csr_axi_regs_if: AXI4 MMIO bus between the PCIe MMIO fabric and the FME CSR block
interface fme_csr_axi_regs_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64,
    parameter int TID_WIDTH  = 10
);
    logic                    awvalid, awready;
    logic [TID_WIDTH-1:0]    awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid, wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [TID_WIDTH-1:0]    bid;
    logic [1:0]              bresp;
    logic                    arvalid, arready;
    logic [TID_WIDTH-1:0]    arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid, rready;
    logic [TID_WIDTH-1:0]    rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awid, awaddr, wvalid, wdata, wstrb, bready, arvalid, arid, araddr, rready,
        output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );
    modport master (
        output awvalid, awid, awaddr, wvalid, wdata, wstrb, bready, arvalid, arid, araddr, rready,
        input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );
endinterface

// File: rtl/fme_csr_axi_slave.sv
// fme_csr_axi_slave: AXI4 handshake and ID capture, presenting single-cycle write/read strobes
module fme_csr_axi_slave
    import fme_csr_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64,
    parameter int TID_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fme_csr_axi_regs_if.slave       axi,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-4:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-4:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data
);
    logic                    rdy_q, rdy_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [TID_WIDTH-1:0]    awid_q, awid_d, bid_q, bid_d, rid_q, rid_d;
    logic [ADDR_WIDTH-4:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    aw_hs, w_hs, ar_hs;

    // Ready stays low during reset and for one write/read until its response is taken
    assign axi.awready = rdy_q & ~aw_held_q & ~bvalid_q;
    assign axi.wready  = rdy_q & ~w_held_q & ~bvalid_q;
    assign axi.arready = rdy_q & ~rvalid_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = RESP_OKAY;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = RESP_OKAY;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;
    assign ar_hs = axi.arvalid & axi.arready;

    // Commit as soon as both halves are present, bypassing the holding regs for a live beat
    assign wr_en   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : axi.awaddr[ADDR_WIDTH-1:3];
    assign wr_data = w_held_q ? wdata_q : axi.wdata;
    assign wr_strb = w_held_q ? wstrb_q : axi.wstrb;
    assign rd_en   = ar_hs;
    assign rd_addr = axi.araddr[ADDR_WIDTH-1:3];

    always_comb begin
        rdy_d     = 1'b1;
        aw_held_d = (aw_held_q | aw_hs) & ~wr_en;
        w_held_d  = (w_held_q | w_hs) & ~wr_en;
        awid_d    = aw_hs ? axi.awid : awid_q;
        awaddr_d  = aw_hs ? axi.awaddr[ADDR_WIDTH-1:3] : awaddr_q;
        wdata_d   = w_hs ? axi.wdata : wdata_q;
        wstrb_d   = w_hs ? axi.wstrb : wstrb_q;
        bvalid_d  = wr_en | (bvalid_q & ~axi.bready);
        bid_d     = wr_en ? (aw_held_q ? awid_q : axi.awid) : bid_q;
        rvalid_d  = ar_hs | (rvalid_q & ~axi.rready);
        rid_d     = ar_hs ? axi.arid : rid_q;
        rdata_d   = ar_hs ? rd_data : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            rdy_q     <= rdy_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: rtl/fme_csr_axi_regs.sv
// fme_csr_axi_regs: FME CSR file (DFH, AFU ID, bitstream info, scratchpad, fabric status, sticky errors)
module fme_csr_axi_regs
    import fme_csr_pkg::*;
#(
    parameter int            ADDR_WIDTH   = 20,
    parameter int            DATA_WIDTH   = 64,
    parameter int            TID_WIDTH    = 10,
    parameter logic [63:0]   BITSTREAM_ID = 64'h0,
    parameter logic [63:0]   BITSTREAM_MD = 64'h0,
    parameter logic [127:0]  FME_AFU_ID   = 128'hF9E17AB5_9B0A_4C3A_8A0B_B58E5E5E7F44
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fme_csr_axi_regs_if.slave     axi,
    input  logic [DATA_WIDTH-1:0] fab_capability_i,
    input  logic [DATA_WIDTH-1:0] fab_status_i,
    input  logic [DATA_WIDTH-1:0] error_set_i,
    output logic [DATA_WIDTH-1:0] scratchpad_o,
    output logic [DATA_WIDTH-1:0] error_mask_o,
    output logic [DATA_WIDTH-1:0] error_o
);
    logic                    wr_en, rd_en;
    logic [ADDR_WIDTH-4:0]   wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   wr_data, rd_data, m, clr;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [DATA_WIDTH-1:0]   scratch_q, scratch_d, mask_q, mask_d, error_q, error_d;

    function automatic logic [ADDR_WIDTH-4:0] w(input int unsigned off);
        return off[ADDR_WIDTH-1:3];
    endfunction

    fme_csr_axi_slave #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .TID_WIDTH (TID_WIDTH)
    ) u_slave (
        .clk    (clk),
        .rst_n  (rst_n),
        .axi    (axi),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        rd_data = '0;
        if (rd_en)
            case (rd_addr)
                w(FME_DFH_OFF):        rd_data = FME_DFH;
                w(AFU_ID_L_OFF):       rd_data = FME_AFU_ID[63:0];
                w(AFU_ID_H_OFF):       rd_data = FME_AFU_ID[127:64];
                w(SCRATCHPAD0_OFF):    rd_data = scratch_q;
                w(FAB_CAPABILITY_OFF): rd_data = fab_capability_i;
                w(FAB_STATUS_OFF):     rd_data = fab_status_i;
                w(BITSTREAM_ID_OFF):   rd_data = BITSTREAM_ID;
                w(BITSTREAM_MD_OFF):   rd_data = BITSTREAM_MD;
                w(FME_ERROR_MASK_OFF): rd_data = mask_q;
                w(FME_ERROR_OFF):      rd_data = error_q;
                default:               rd_data = '0;
            endcase
    end

    assign m = strb_mask(wr_strb);

    // New error events override a simultaneous write-1-to-clear on the same bit
    always_comb begin
        scratch_d = (wr_en && wr_addr == w(SCRATCHPAD0_OFF)) ? (scratch_q & ~m) | (wr_data & m) : scratch_q;
        mask_d    = (wr_en && wr_addr == w(FME_ERROR_MASK_OFF)) ? (mask_q & ~m) | (wr_data & m) : mask_q;
        clr       = (wr_en && wr_addr == w(FME_ERROR_OFF)) ? wr_data & m : '0;
        error_d   = (error_q & ~clr) | (error_set_i & ~mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q <= SCRATCHPAD_RST;
            mask_q    <= ERROR_MASK_RST;
            error_q   <= ERROR_RST;
        end else begin
            scratch_q <= scratch_d;
            mask_q    <= mask_d;
            error_q   <= error_d;
        end
    end

    assign scratchpad_o = scratch_q;
    assign error_mask_o = mask_q;
    assign error_o      = error_q;
endmodule

// File: tb/tb_fme_csr_axi_regs.sv
// tb_fme_csr_axi_regs: scoreboard bench for the FME CSR register file
module tb_fme_csr_axi_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] fab_cap, fab_stat, err_set, scratch, mask, err;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [9:0]  id;
        logic [63:0] data;
    } exp_t;
    exp_t       rq[$];
    logic [9:0] bq[$];

    always #5 clk = ~clk;

    fme_csr_axi_regs_if #(.ADDR_WIDTH(20), .DATA_WIDTH(64), .TID_WIDTH(10)) axi();

    fme_csr_axi_regs dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi             (axi),
        .fab_capability_i(fab_cap),
        .fab_status_i    (fab_stat),
        .error_set_i     (err_set),
        .scratchpad_o    (scratch),
        .error_mask_o    (mask),
        .error_o         (err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic pulse(input logic [63:0] v);
        @(negedge clk);
        err_set = v;
        @(posedge clk);
        #1 err_set = '0;
    endtask

    task automatic b_drain(input logic [9:0] id, input int stall);
        int c;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("b_hold", {63'b0, axi.bvalid}, 64'd1);
            check("b_hold_id", {54'b0, axi.bid}, {54'b0, id});
            check("aw_blocked", {62'b0, axi.awready, axi.wready}, 64'd0);
        end
        axi.bready = 1'b1;
        c = 0;
        while (!axi.bvalid && c < 20) begin @(negedge clk); c++; end
        if (axi.bvalid) begin
            check("bid", {54'b0, axi.bid}, {54'b0, bq.pop_front()});
            check("bresp", {62'b0, axi.bresp}, 64'd0);
        end else begin
            check("b_timeout", 64'd0, 64'd1);
            void'(bq.pop_front());
        end
        @(posedge clk);
        #1 axi.bready = 1'b0;
    endtask

    task automatic wr(input logic [19:0] a, input logic [63:0] d, input logic [7:0] s, input logic [9:0] id,
                      input int w_lag = 0, input logic [63:0] pls = '0, input int stall = 0);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int c = 0;
        bq.push_back(id);
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awaddr = a; axi.awid = id;
        axi.wdata = d; axi.wstrb = s;
        while (!(aw_done && w_done) && c < 50) begin
            if (c == w_lag && !w_done) axi.wvalid = 1'b1;
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid && axi.wready;
            err_set = ((aw_done || hs_aw) && hs_w) ? pls : '0;
            @(posedge clk);
            #1;
            if (hs_aw) begin aw_done = 1; axi.awvalid = 1'b0; end
            if (hs_w) begin w_done = 1; axi.wvalid = 1'b0; end
            err_set = '0;
            c++;
            @(negedge clk);
        end
        check("bvalid_lat", {63'b0, axi.bvalid}, 64'd1);
        b_drain(id, stall);
    endtask

    task automatic rd(input logic [19:0] a, input logic [9:0] id, input logic [63:0] exp, input int stall = 0);
        int c = 0;
        exp_t e;
        rq.push_back('{id: id, data: exp});
        @(negedge clk);
        axi.arvalid = 1'b1; axi.araddr = a; axi.arid = id;
        while (!axi.arready && c < 20) begin @(negedge clk); c++; end
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_lat", {63'b0, axi.rvalid}, 64'd1);
        for (int i = 0; i < stall; i++) begin
            check("r_hold", axi.rdata, exp);
            check("ar_blocked", {63'b0, axi.arready}, 64'd0);
            @(negedge clk);
            check("r_hold_v", {63'b0, axi.rvalid}, 64'd1);
        end
        axi.rready = 1'b1;
        c = 0;
        while (!axi.rvalid && c < 20) begin @(negedge clk); c++; end
        e = rq.pop_front();
        if (axi.rvalid) begin
            check($sformatf("rdata@%h", a), axi.rdata, e.data);
            check("rid", {54'b0, axi.rid}, {54'b0, e.id});
            check("rresp", {62'b0, axi.rresp}, 64'd0);
        end else check("r_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 axi.rready = 1'b0;
    endtask

    initial begin
        exp_t e;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.bready = 0; axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.rready = 0;
        fab_cap = 64'hCAFE_0000_1234_5678; fab_stat = 64'h0; err_set = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {61'b0, axi.awready, axi.wready, axi.arready}, 64'd0);
        check("rst_valid", {62'b0, axi.bvalid, axi.rvalid}, 64'd0);
        check("rst_rdata", axi.rdata, 64'd0);
        check("rst_regs", scratch | mask | err, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {61'b0, axi.awready, axi.wready, axi.arready}, 64'd7);

        rd(20'h0000, 10'd5, 64'h4000_0000_4000_1000);
        rd(20'h0008, 10'd6, 64'h8A0B_B58E_5E5E_7F44);
        rd(20'h0010, 10'd7, 64'hF9E1_7AB5_9B0A_4C3A);
        rd(20'h0018, 10'd8, 64'h0);
        rd(20'h0034, 10'd9, 64'hCAFE_0000_1234_5678);
        fab_stat = 64'h0123_4567_89AB_CDEF;
        rd(20'h0058, 10'd10, 64'h0123_4567_89AB_CDEF);
        rd(20'h0060, 10'd11, 64'h0);
        rd(20'h0068, 10'd12, 64'h0);

        wr(20'h0028, 64'hDEAD_BEEF_0123_4567, 8'hFF, 10'd21, 2);
        check("scratchpad_o", scratch, 64'hDEAD_BEEF_0123_4567);
        rd(20'h0028, 10'd22, 64'hDEAD_BEEF_0123_4567);
        wr(20'h0028, 64'h0, 8'hFF, 10'd23);
        wr(20'h0028, '1, 8'h0F, 10'd24);
        rd(20'h0028, 10'd25, 64'h0000_0000_FFFF_FFFF);

        wr(20'h4000, 64'h2, 8'hFF, 10'd30);
        check("mask_o", mask, 64'h2);
        pulse(64'h3);
        @(negedge clk);
        check("error_o", err, 64'h1);
        rd(20'h4008, 10'd31, 64'h1);
        wr(20'h4008, '1, 8'h00, 10'd32);
        rd(20'h4008, 10'd33, 64'h1);
        wr(20'h4008, 64'h1, 8'hFF, 10'd34);
        rd(20'h4008, 10'd35, 64'h0);
        pulse(64'h1);
        wr(20'h4008, 64'h1, 8'h01, 10'd36, 0, 64'h1);
        rd(20'h4008, 10'd37, 64'h1);
        rd(20'h4000, 10'd38, 64'h2);

        rd(20'h0100, 10'd40, 64'h0);
        wr(20'h0100, '1, 8'hFF, 10'd41);
        check("unmapped_wr", scratch ^ mask ^ err, 64'h0000_0000_FFFF_FFFF ^ 64'h2 ^ 64'h1);

        wr(20'h0028, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF, 10'd50, 1, '0, 5);
        rd(20'h0028, 10'd51, 64'hA5A5_5A5A_A5A5_5A5A, 5);

        // write commit and read of the same register in one cycle
        @(negedge clk);
        check("conc_ready", {61'b0, axi.awready, axi.wready, axi.arready}, 64'd7);
        axi.awvalid = 1; axi.awaddr = 20'h0028; axi.awid = 10'd60; axi.wvalid = 1;
        axi.wdata = 64'h1111_2222_3333_4444; axi.wstrb = 8'hFF;
        axi.arvalid = 1; axi.araddr = 20'h0028; axi.arid = 10'd61;
        bq.push_back(10'd60);
        rq.push_back('{id: 10'd61, data: 64'hA5A5_5A5A_A5A5_5A5A});
        @(posedge clk);
        #1 begin axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; end
        @(negedge clk);
        check("conc_v", {62'b0, axi.bvalid, axi.rvalid}, 64'd3);
        check("conc_bid", {54'b0, axi.bid}, {54'b0, bq.pop_front()});
        e = rq.pop_front();
        check("conc_rdata", axi.rdata, e.data);
        check("conc_rid", {54'b0, axi.rid}, {54'b0, e.id});
        axi.bready = 1; axi.rready = 1;
        @(posedge clk);
        #1 begin axi.bready = 0; axi.rready = 0; end
        rd(20'h0028, 10'd62, 64'h1111_2222_3333_4444);

        // reset with an address beat accepted but no data beat
        @(negedge clk);
        axi.awvalid = 1; axi.awaddr = 20'h0028; axi.awid = 10'd70;
        @(posedge clk);
        #1 axi.awvalid = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        axi.wvalid = 1; axi.wdata = '1; axi.wstrb = 8'hFF;
        @(posedge clk);
        #1 axi.wvalid = 0;
        repeat (3) begin
            @(negedge clk);
            check("abort_nob", {63'b0, axi.bvalid}, 64'd0);
        end
        check("abort_regs", scratch | mask | err, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
